// File: rtl/sid_arb_pkg.sv
// Shared definitions for the SID/DIP bus arbiter: FSM encoding, grant
// encoding and the legal range of the device wait time.
package sid_arb_pkg;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam logic GNT_HOST = 1'b0;
    localparam logic GNT_LDR  = 1'b1;

    // The device is selected only while a transfer is actually on the bus.
    function automatic logic sid_active(input logic [2:0] st);
        return (st == ST_SETUP) || (st == ST_WAIT) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/sid_wait_timer.sv
// Down-counter that times the device access window; expired marks the
// last wait cycle so the FSM leaves WAIT after exactly the loaded count.
module sid_wait_timer
    import sid_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             enable_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = count_i;
        end else if (enable_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sid_bus_arbiter.sv
// Arbitrates the SID/DIP device between Zorro III host slave cycles and the
// internal config loader, and sequences the select/wait/ack handshake.
module sid_bus_arbiter
    import sid_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FCS_n,
    input  logic       host_req,
    input  logic       host_read,
    input  logic [7:0] host_din,
    output logic [7:0] host_dout,
    output logic       host_dtack,
    input  logic       ldr_req,
    input  logic       ldr_read,
    input  logic [7:0] ldr_din,
    output logic [7:0] ldr_dout,
    output logic       ldr_ack,
    output logic       SID_n,
    output logic       DEV_READ,
    output logic [7:0] DEV_WDATA,
    input  logic [7:0] DEV_RDATA
);

    logic [2:0] state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic       dev_read_q, dev_read_d;
    logic [7:0] dev_wdata_q, dev_wdata_d;
    logic [7:0] host_dout_q, host_dout_d;
    logic [7:0] ldr_dout_q, ldr_dout_d;
    logic       dtack_q, dtack_d;
    logic       ack_q, ack_d;
    logic       sid_n_q, sid_n_d;

    logic host_elig_s;
    logic pick_s;
    logic host_abort_s;
    logic load_s;
    logic en_s;
    logic expired_s;

    assign host_elig_s  = host_req && !FCS_n;
    // On a tie the requester that did not win last time gets the bus.
    assign pick_s       = (host_elig_s && ldr_req) ? ((last_q == GNT_LDR) ? GNT_HOST : GNT_LDR)
                                                   : (host_elig_s ? GNT_HOST : GNT_LDR);
    assign host_abort_s = (gnt_q == GNT_HOST) && FCS_n;

    sid_wait_timer u_timer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .load_i    (load_s),
        .count_i   (CNT_W'(WAIT_CYCLES)),
        .enable_i  (en_s),
        .expired_o (expired_s)
    );

    // Transfer sequencing and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        dev_read_d  = dev_read_q;
        dev_wdata_d = dev_wdata_q;
        host_dout_d = host_dout_q;
        ldr_dout_d  = ldr_dout_q;
        dtack_d     = dtack_q;
        ack_d       = 1'b0;
        load_s      = 1'b0;
        en_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_elig_s || ldr_req) begin
                    state_d = ST_SETUP;
                    gnt_d   = pick_s;
                    last_d  = pick_s;
                    if (pick_s == GNT_HOST) begin
                        dev_read_d  = host_read;
                        dev_wdata_d = host_din;
                    end else begin
                        dev_read_d  = ldr_read;
                        dev_wdata_d = ldr_din;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (host_abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    load_s  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (host_abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    en_s = 1'b1;
                    if (expired_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                if (dev_read_q && (gnt_q == GNT_HOST)) begin
                    host_dout_d = DEV_RDATA;
                end else if (dev_read_q) begin
                    ldr_dout_d = DEV_RDATA;
                end else begin
                    host_dout_d = host_dout_q;
                end
                if (gnt_q == GNT_LDR) begin
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    dtack_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (FCS_n) begin
                    dtack_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sid_n_d = !sid_active(state_d);
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_LDR;
            last_q      <= GNT_LDR;
            dev_read_q  <= 1'b1;
            dev_wdata_q <= 8'h00;
            host_dout_q <= 8'hFF;
            ldr_dout_q  <= 8'hFF;
            dtack_q     <= 1'b0;
            ack_q       <= 1'b0;
            sid_n_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            dev_read_q  <= dev_read_d;
            dev_wdata_q <= dev_wdata_d;
            host_dout_q <= host_dout_d;
            ldr_dout_q  <= ldr_dout_d;
            dtack_q     <= dtack_d;
            ack_q       <= ack_d;
            sid_n_q     <= sid_n_d;
        end
    end

    assign host_dout  = host_dout_q;
    assign host_dtack = dtack_q;
    assign ldr_dout   = ldr_dout_q;
    assign ldr_ack    = ack_q;
    assign SID_n      = sid_n_q;
    assign DEV_READ   = dev_read_q;
    assign DEV_WDATA  = dev_wdata_q;

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// Self-checking bench for sid_bus_arbiter: directed transaction table,
// reset sequences and randomized transactions against a transaction model.
module tb_sid_bus_arbiter;

    localparam int W = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       FCS_n, host_req, host_read, ldr_req, ldr_read;
    logic [7:0] host_din, ldr_din, DEV_RDATA;
    logic [7:0] host_dout, ldr_dout, DEV_WDATA;
    logic       host_dtack, ldr_ack, SID_n, DEV_READ;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         use_h, use_l, h_rd, l_rd;
        logic [7:0] h_wd, l_wd, rd_a, rd_b;
        int         abort_at, h_hold;
        logic [7:0] exp_h, exp_l;
        bit         first_host;
    } txn_t;

    txn_t tbl[7];

    sid_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .CLK(CLK), .RESET(RESET), .FCS_n(FCS_n),
        .host_req(host_req), .host_read(host_read), .host_din(host_din),
        .host_dout(host_dout), .host_dtack(host_dtack),
        .ldr_req(ldr_req), .ldr_read(ldr_read), .ldr_din(ldr_din),
        .ldr_dout(ldr_dout), .ldr_ack(ldr_ack),
        .SID_n(SID_n), .DEV_READ(DEV_READ), .DEV_WDATA(DEV_WDATA),
        .DEV_RDATA(DEV_RDATA)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk(nm, {4'h0, SID_n, DEV_READ, DEV_WDATA, host_dtack, ldr_ack, host_dout, ldr_dout},
                {4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF});
    endtask

    task automatic idle_inputs();
        FCS_n = 1'b1; host_req = 1'b0; host_read = 1'b0; host_din = 8'h00;
        ldr_req = 1'b0; ldr_read = 1'b0; ldr_din = 8'h00; DEV_RDATA = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    // Run one transaction (one or two requesters) and check it against t.
    task automatic run_txn(input txn_t t);
        bit own_host[2];
        int exp_len[2];
        int n, win, cur, t0, hold, hst, lst;
        bit bad, spur, done, ord0_host;
        int nord;
        n = (t.use_h ? 1 : 0) + (t.use_l ? 1 : 0);
        own_host[0] = (t.use_h && t.use_l) ? t.first_host : t.use_h;
        own_host[1] = !own_host[0];
        for (int i = 0; i < 2; i++)
            exp_len[i] = (own_host[i] && t.abort_at >= 0) ? t.abort_at + 1 : W + 2;
        host_req = t.use_h; FCS_n = !t.use_h; host_read = t.h_rd; host_din = t.h_wd;
        ldr_req = t.use_l; ldr_read = t.l_rd; ldr_din = t.l_wd; DEV_RDATA = t.rd_a;
        win = 0; cur = 0; t0 = 0; hold = t.h_hold; nord = 0;
        bad = 1'b0; spur = 1'b0; done = 1'b0; ord0_host = 1'b0;
        hst = t.use_h ? 1 : 0;
        lst = t.use_l ? 1 : 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            tick();
            if (!SID_n) begin
                if (cur == 0) t0 = cyc;
                cur++;
                if (win < 2) begin
                    if (DEV_READ !== (own_host[win] ? t.h_rd : t.l_rd) ||
                        DEV_WDATA !== (own_host[win] ? t.h_wd : t.l_wd)) bad = 1'b1;
                    if (own_host[win] && t.abort_at >= 0 && cur == t.abort_at + 1) begin
                        FCS_n = 1'b1; host_req = 1'b0; hst = 0;
                    end
                end
            end else if (cur > 0) begin
                chk("win_len", cur, (win < 2) ? exp_len[win] : 0);
                chk("dev_bus", 32'(bad), 32'd0);
                bad = 1'b0; cur = 0; win++;
                DEV_RDATA = t.rd_b;
            end
            case (lst)
                1: if (ldr_ack) begin
                    chk("ldr_latency", cyc - t0, W + 2);
                    if (nord == 0) ord0_host = 1'b0;
                    nord++; ldr_req = 1'b0; lst = 2;
                end
                2: begin chk("ldr_ack_pulse", 32'(ldr_ack), 32'd0); lst = 0; end
                default: if (ldr_ack) spur = 1'b1;
            endcase
            case (hst)
                1: if (host_dtack) begin
                    chk("host_latency", cyc - t0, W + 2);
                    if (nord == 0) ord0_host = 1'b1;
                    nord++;
                    if (hold == 0) begin FCS_n = 1'b1; host_req = 1'b0; hst = 3; end
                    else hst = 2;
                end
                2: begin
                    chk("dtack_hold", 32'(host_dtack), 32'd1);
                    hold--;
                    if (hold == 0) begin FCS_n = 1'b1; host_req = 1'b0; hst = 3; end
                end
                3: begin chk("dtack_release", 32'(host_dtack), 32'd0); hst = 0; end
                default: if (host_dtack) spur = 1'b1;
            endcase
            done = (hst == 0) && (lst == 0) && (cur == 0);
        end
        chk("timeout", 32'(done), 32'd1);
        idle_inputs();
        repeat (2) begin
            tick();
            if (host_dtack || ldr_ack) spur = 1'b1;
        end
        chk("spurious_ack", 32'(spur), 32'd0);
        chk("windows", win, n);
        if (t.use_h && t.use_l) chk("first_served", 32'(ord0_host), 32'(t.first_host));
        chk("host_dout", 32'(host_dout), 32'(t.exp_h));
        chk("ldr_dout", 32'(ldr_dout), 32'(t.exp_l));
    endtask

    initial begin
        txn_t t;
        bit m_last_host;
        logic [7:0] m_h, m_l;
        int mode;
        bit host_win1;

        idle_inputs();
        RESET = 1'b0;
        #1 RESET = 1'b1;
        #1 chk_reset_vals("reset_async");
        do_reset();
        chk_reset_vals("reset_release");

        // Host read aborted during WAIT straight after reset.
        t = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h5B, 8'h00, 1, 0, 8'hFF, 8'hFF, 1'b1};
        run_txn(t);

        // Reset pulsed during WAIT of a loader read.
        ldr_req = 1'b1; ldr_read = 1'b1; DEV_RDATA = 8'h3A;
        for (int c = 0; c < 10 && SID_n; c++) tick();
        chk("rst_mid_grant", 32'(SID_n), 32'd0);
        tick();
        RESET = 1'b1;
        #1 chk_reset_vals("rst_mid_values");
        ldr_req = 1'b0;
        tick();
        RESET = 1'b0;
        begin
            bit seen_ack = 1'b0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (ldr_ack) seen_ack = 1'b1;
            end
            chk("rst_mid_no_ack", 32'(seen_ack), 32'd0);
        end
        chk_reset_vals("rst_mid_after");

        // Directed transaction table, starting from reset.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h5A, 8'hC3, -1, 0, 8'h5A, 8'hC3, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h00, -1, 0, 8'h5A, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00, -1, 5, 8'h5A, 8'hA5, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h77, 8'h00, 8'h96, -1, 0, 8'h96, 8'hA5, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE1, 8'h00, 1, 0, 8'h96, 8'hA5, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE2, 8'h00, 0, 0, 8'h96, 8'hA5, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 8'h00, 8'h0F, 8'hEE, -1, 0, 8'h96, 8'h0F, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Randomized transactions against a transaction-level model.
        do_reset();
        m_last_host = 1'b0;
        m_h = 8'hFF;
        m_l = 8'hFF;
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 3));
            t.use_h = (mode != 0);
            t.use_l = (mode == 0) || (mode == 2);
            t.h_rd = 1'($urandom_range(0, 1));
            t.l_rd = 1'($urandom_range(0, 1));
            t.h_wd = 8'($urandom_range(0, 255));
            t.l_wd = 8'($urandom_range(0, 255));
            t.rd_a = 8'($urandom_range(0, 255));
            t.rd_b = 8'($urandom_range(0, 255));
            t.abort_at = (mode == 3) ? int'($urandom_range(0, W)) : -1;
            t.h_hold = int'($urandom_range(0, 3));
            t.first_host = t.use_h && (!t.use_l || !m_last_host);
            host_win1 = t.use_l && !t.first_host;
            if (t.use_h && t.h_rd && t.abort_at < 0) m_h = host_win1 ? t.rd_b : t.rd_a;
            if (t.use_l && t.l_rd) m_l = (t.use_h && t.first_host) ? t.rd_b : t.rd_a;
            t.exp_h = m_h;
            t.exp_l = m_l;
            m_last_host = (t.use_h && t.use_l) ? !t.first_host : t.use_h;
            run_txn(t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_bus_arbiter.md
SID_BUS_ARBITER -- requirements
Module: sid_bus_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2; number of cycles SID_n is held low before read data is sampled (legal range 1-15).
REQ-002 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 FCS_n  input  1  Zorro III full-cycle strobe, active low.
REQ-005 host_req  input  1  level; host slave cycle decoded to SID/DIP region.
REQ-006 host_read  input  1  1 = host read, 0 = host write; valid while host_req is high.
REQ-007 host_din  input  8  host write data.
REQ-008 host_dout  output  8  host read data.
REQ-009 host_dtack  output  1  host data acknowledge.
REQ-010 ldr_req  input  1  level request from the internal config loader.
REQ-011 ldr_read  input  1  loader direction, same encoding as host_read.
REQ-012 ldr_din  input  8  loader write data.
REQ-013 ldr_dout  output  8  loader read data.
REQ-014 ldr_ack  output  1  one-cycle completion pulse to the loader.
REQ-015 SID_n  output  1  device select, active low.
REQ-016 DEV_READ  output  1  device direction, 1 = read.
REQ-017 DEV_WDATA  output  8  device write data.
REQ-018 DEV_RDATA  input  8  device read data.

Function
REQ-019 FSM states: IDLE, SETUP, WAIT, DONE, HOLD; SID_n is low only in SETUP, WAIT and DONE.
REQ-020 IDLE: with exactly one requester asserted, grant it and go to SETUP on the next edge.
REQ-021 IDLE, both requesting: grant the requester that was not granted last (round-robin); the last-grant flag updates on every grant, including aborted grants.
REQ-022 A host request is eligible only while FCS_n = 0.
REQ-023 On grant: latch direction and write data; DEV_READ and DEV_WDATA hold those latched values until the FSM returns to IDLE.
REQ-024 SETUP -> WAIT after 1 cycle; WAIT lasts exactly WAIT_CYCLES cycles, counted by a down-counter loaded on entry; then -> DONE.
REQ-025 DONE, read: capture DEV_RDATA into host_dout or ldr_dout according to the grant; the other data output is unchanged.
REQ-026 DONE, loader grant: pulse ldr_ack for exactly 1 cycle, then return to IDLE.
REQ-027 DONE, host grant: assert host_dtack, then go to HOLD; host_dtack stays high in HOLD.
REQ-028 HOLD: SID_n is high; when FCS_n = 1, deassert host_dtack and return to IDLE on the same edge.
REQ-029 Latency: from the grant edge to ack/dtack high is WAIT_CYCLES+2 cycles (4 at the default).
REQ-030 Host abort: if FCS_n = 1 in SETUP or WAIT, go to IDLE on the next edge; raise SID_n; no dtack; host_dout is unchanged.
REQ-031 Loader requests are never aborted; ldr_req deasserting mid-transfer has no effect.
REQ-032 Back-to-back transfers: the FSM always passes through IDLE for at least 1 cycle, so SID_n is high for at least 1 cycle between transfers.

Reset
REQ-033 While RESET = 1, regardless of CLK: state = IDLE, SID_n = 1, DEV_READ = 1, DEV_WDATA = 8'h00, host_dtack = 0, ldr_ack = 0, host_dout = 8'hFF, ldr_dout = 8'hFF, wait counter = 0.
REQ-034 On reset, the last-grant flag is set to loader, so the host wins the first tie.
REQ-035 Reset mid-transfer abandons the transfer; no ack is produced after reset releases.

Structure
REQ-036 Shared package sid_arb_pkg holds: the FSM state encoding, the grant encoding (GNT_HOST, GNT_LDR), and the WAIT_CYCLES range limits.
REQ-037 The wait counter is a sub-module, sid_wait_timer, with inputs load, count value and enable, and output expired.

Verification (WAIT_CYCLES = 2)
REQ-038 Loader read, DEV_RDATA = 8'hA5 -> SID_n low for 4 cycles; ldr_dout = 8'hA5; ldr_ack high for 1 cycle, 4 cycles after the grant.
REQ-039 Host write of 8'h3C, FCS_n held low 10 cycles -> DEV_READ = 0 and DEV_WDATA = 8'h3C while SID_n is low; host_dtack high from cycle 4 until the edge after FCS_n rises.
REQ-040 Host and loader request on the same edge after reset -> host served first, loader second; SID_n high for at least 1 cycle between the two transfers.
REQ-041 Host read with FCS_n rising during WAIT -> SID_n high on the next edge; host_dtack never asserts; host_dout stays 8'hFF.
REQ-042 RESET pulsed during WAIT of a loader read -> all outputs at reset values immediately; no ldr_ack after release.
